// File: rtl/mem_burst_master_if.sv
// Host request/data channel plus memory strobe channel of the burst master.
// The master modport is the controller side; slave is the host plus memory side.
interface mem_burst_master_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          done;
  logic          err;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, mem_rdata,
    output req_ready, wdata_ready, rdata_valid, rdata, done, err,
           mem_wr, mem_rd, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, mem_rdata,
    input  req_ready, wdata_ready, rdata_valid, rdata, done, err,
           mem_wr, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port register-file memory: one strobe per
// cycle with address wrap at DEPTH-1, read data passed through from the memory.
module mem_burst_master #(
  parameter int DEPTH = 11,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic               Clk,
  input  logic               rst,
  mem_burst_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] r_remaining;
  logic          r_rdata_valid;
  logic          r_done;
  logic          r_err;

  logic [AW-1:0] w_next_addr;
  logic          w_req_bad;
  logic          w_mem_wr;
  logic          w_mem_rd;
  logic [DW-1:0] w_rdata;

  assign w_next_addr = (r_cur_addr == LAST_ADDR) ? '0 : r_cur_addr + 1'b1;
  assign w_req_bad   = (bus.req_addr > LAST_ADDR) || (bus.req_len > LAST_ADDR);
  assign w_mem_wr    = (r_state == WRITE) && bus.wdata_valid;
  assign w_mem_rd    = (r_state == READ);
  assign w_rdata     = bus.mem_rdata;

  // req_ready is gated by rst so nothing is offered while reset is held
  assign bus.req_ready   = !rst && (r_state == IDLE);
  assign bus.wdata_ready = (r_state == WRITE);
  assign bus.mem_wr      = w_mem_wr;
  assign bus.mem_rd      = w_mem_rd;
  assign bus.mem_addr    = r_cur_addr;
  assign bus.mem_wdata   = bus.wdata;
  assign bus.rdata       = w_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= w_mem_rd;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else begin
              r_cur_addr  <= bus.req_addr;
              r_remaining <= bus.req_len;
              r_state     <= bus.req_write ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (bus.wdata_valid) begin
            r_cur_addr <= w_next_addr;
            if (r_remaining == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end
        READ: begin
          r_cur_addr <= w_next_addr;
          if (r_remaining == '0) r_state <= DRAIN;
          else                   r_remaining <= r_remaining - 1'b1;
        end
        DRAIN: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_master.sv
// Randomised scoreboard bench for mem_burst_master with a behavioural memory
// and a transaction-level reference model of burst contents and timing.
module tb_mem_burst_master;
  localparam int DEPTH = 11;
  localparam int AW    = 4;
  localparam int DW    = 8;

  typedef struct { bit wr; int addr; int data; int cyc; } strobe_t;
  typedef struct { int data; int cyc; } rbeat_t;
  typedef struct { bit is_err; int cyc; } evt_t;

  logic Clk = 1'b0;
  logic rst = 1'b1;
  always #5 Clk = ~Clk;

  mem_burst_master_if #(.AW(AW), .DW(DW)) bus ();

  mem_burst_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  strobe_t sq[$];
  rbeat_t  rq[$];
  evt_t    evq[$];

  int        ref_mem [DEPTH];
  logic [7:0] mem_arr [16];
  logic [7:0] beat_d  [16];
  int         beat_st [16];

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural register-file memory: registered read, undefined when idle
  always @(posedge Clk) begin
    if (bus.mem_wr) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem_arr[bus.mem_addr];
    else            bus.mem_rdata <= 'x;
  end

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe, read beat or pulse
  always @(negedge Clk) begin
    strobe_t s;
    rbeat_t  r;
    evt_t    e;
    if (!rst) begin
      if (bus.mem_wr || bus.mem_rd) begin
        if (sq.size() == 0) begin
          chk(1'b0, "unexpected_strobe", $sformatf("wr=%0b rd=%0b addr=%0d cyc=%0d, required none",
              bus.mem_wr, bus.mem_rd, bus.mem_addr, cyc));
        end else begin
          s = sq.pop_front();
          chk((bus.mem_wr == s.wr) && (bus.mem_rd == !s.wr) && (int'(bus.mem_addr) == s.addr) &&
              (!s.wr || int'(bus.mem_wdata) == s.data) && (cyc == s.cyc), "strobe",
              $sformatf("got wr=%0b rd=%0b addr=%0d data=%02h cyc=%0d, required wr=%0b addr=%0d data=%02h cyc=%0d",
              bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata, cyc, s.wr, s.addr, s.data, s.cyc));
        end
      end
      if (bus.rdata_valid) begin
        if (rq.size() == 0) begin
          chk(1'b0, "unexpected_rdata", $sformatf("rdata=%02h cyc=%0d, required none", bus.rdata, cyc));
        end else begin
          r = rq.pop_front();
          chk((int'(bus.rdata) == r.data) && (cyc == r.cyc), "rdata",
              $sformatf("got %02h at cyc %0d, required %02h at cyc %0d", bus.rdata, cyc, r.data, r.cyc));
        end
      end
      if (bus.done || bus.err) begin
        if (evq.size() == 0) begin
          chk(1'b0, "unexpected_pulse", $sformatf("done=%0b err=%0b cyc=%0d, required none",
              bus.done, bus.err, cyc));
        end else begin
          e = evq.pop_front();
          chk((bus.err == e.is_err) && (bus.done == !e.is_err) && (cyc == e.cyc), "pulse",
              $sformatf("got done=%0b err=%0b cyc=%0d, required err=%0b cyc=%0d",
              bus.done, bus.err, cyc, e.is_err, e.cyc));
        end
      end
    end
  end

  // Presents one request, records the reference outcome, then feeds write beats
  task automatic send_req(input bit wr, input int addr, input int len, output int c0);
    int n   = 0;
    int acc = 0;
    int a;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = AW'(addr);
    bus.req_len   = AW'(len);
    forever begin
      @(negedge Clk);
      if (bus.req_ready) break;
      n++;
      if (n > 60) begin
        chk(1'b0, "accept_timeout", $sformatf("req_ready=0 for %0d cycles, required 1", n));
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "request never accepted");
      end
    end
    c0 = cyc + 1;
    if (addr >= DEPTH || len >= DEPTH) begin
      evq.push_back('{1'b1, c0});
    end else if (wr) begin
      for (int i = 0; i <= len; i++) begin
        acc += beat_st[i];
        a = (addr + i) % DEPTH;
        ref_mem[a] = int'(beat_d[i]);
        sq.push_back('{1'b1, a, int'(beat_d[i]), c0 + i + acc});
      end
      evq.push_back('{1'b0, c0 + len + 1 + acc});
    end else begin
      for (int i = 0; i <= len; i++) begin
        a = (addr + i) % DEPTH;
        sq.push_back('{1'b0, a, 0, c0 + i});
        rq.push_back('{ref_mem[a], c0 + i + 1});
      end
      evq.push_back('{1'b0, c0 + len + 2});
    end
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    if (wr && addr < DEPTH && len < DEPTH) begin
      for (int i = 0; i <= len; i++) begin
        bus.wdata_valid = 1'b0;
        repeat (beat_st[i]) begin @(posedge Clk); #1; end
        bus.wdata_valid = 1'b1;
        bus.wdata       = beat_d[i];
        @(posedge Clk); #1;
      end
      bus.wdata_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sq.size() != 0 || rq.size() != 0 || evq.size() != 0) begin
      @(negedge Clk);
      n++;
      if (n > 300) begin
        chk(1'b0, "drain_timeout", $sformatf("pending strobes=%0d rdata=%0d pulses=%0d, required 0",
            sq.size(), rq.size(), evq.size()));
        sq.delete(); rq.delete(); evq.delete();
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic set_beats(input int len, input bit rnd_stall);
    for (int i = 0; i < 16; i++) begin
      beat_d[i]  = 8'($urandom);
      beat_st[i] = (rnd_stall && ($urandom % 2 == 0)) ? int'($urandom_range(1, 3)) : 0;
    end
    if (len < 0) beat_st[0] = 0;
  endtask

  initial begin
    int c0, c1, wr, addr, len;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    repeat (2) @(posedge Clk); #1;

    chk(bus.req_ready == 1'b0 && bus.wdata_ready == 1'b0, "reset_ready",
        $sformatf("req_ready=%0b wdata_ready=%0b, required 0 0", bus.req_ready, bus.wdata_ready));
    chk(bus.mem_wr == 1'b0 && bus.mem_rd == 1'b0 && bus.mem_addr == '0, "reset_mem",
        $sformatf("wr=%0b rd=%0b addr=%0d, required 0 0 0", bus.mem_wr, bus.mem_rd, bus.mem_addr));
    chk(bus.rdata_valid == 1'b0 && bus.done == 1'b0 && bus.err == 1'b0, "reset_regs",
        $sformatf("rdata_valid=%0b done=%0b err=%0b, required 0 0 0", bus.rdata_valid, bus.done, bus.err));
    rst = 1'b0; #1;
    chk(bus.req_ready == 1'b1, "ready_after_reset", $sformatf("req_ready=%0b, required 1", bus.req_ready));
    @(posedge Clk); #1;

    // Fill the whole memory so every later read has a known reference value
    set_beats(-1, 1'b0);
    send_req(1'b1, 0, DEPTH - 1, c0); wait_idle();

    set_beats(-1, 1'b0);
    beat_d[0] = 8'hA1; beat_d[1] = 8'hB2; beat_d[2] = 8'hC3;
    send_req(1'b1, 2, 2, c0); wait_idle();
    send_req(1'b0, 2, 2, c0); wait_idle();

    set_beats(-1, 1'b0);
    beat_d[0] = 8'h11; beat_d[1] = 8'h22; beat_d[2] = 8'h33; beat_d[3] = 8'h44;
    send_req(1'b1, 9, 3, c0); wait_idle();
    chk(ref_mem[0] == 32'h33, "wrap_model", $sformatf("model word0=%02h, required 33", ref_mem[0]));
    send_req(1'b0, 0, 0, c0); wait_idle();
    send_req(1'b0, 8, 4, c0); wait_idle();

    send_req(1'b1, 11, 0, c0);
    @(negedge Clk);
    chk(bus.req_ready == 1'b1, "reject_ready", $sformatf("req_ready=%0b, required 1", bus.req_ready));
    wait_idle();
    send_req(1'b0, 3, 11, c0); wait_idle();
    send_req(1'b0, 15, 15, c0); wait_idle();

    set_beats(-1, 1'b0);
    beat_st[1] = 3;
    send_req(1'b1, 5, 1, c0); wait_idle();

    send_req(1'b0, 3, 4, c0);
    @(posedge Clk); #1;
    chk(bus.mem_rd == 1'b1, "rd_before_reset", $sformatf("mem_rd=%0b, required 1", bus.mem_rd));
    rst = 1'b1; #1;
    chk(bus.mem_rd == 1'b0 && bus.rdata_valid == 1'b0 && bus.done == 1'b0 && bus.req_ready == 1'b0,
        "reset_abort", $sformatf("rd=%0b rvalid=%0b done=%0b ready=%0b, required 0 0 0 0",
        bus.mem_rd, bus.rdata_valid, bus.done, bus.req_ready));
    sq.delete(); rq.delete(); evq.delete();
    repeat (2) @(posedge Clk); #1;
    rst = 1'b0; #1;
    chk(bus.rdata_valid == 1'b0 && bus.done == 1'b0 && bus.req_ready == 1'b1, "post_reset",
        $sformatf("rvalid=%0b done=%0b ready=%0b, required 0 0 1", bus.rdata_valid, bus.done, bus.req_ready));
    @(posedge Clk); #1;
    send_req(1'b0, 2, 3, c0); wait_idle();

    set_beats(-1, 1'b0);
    send_req(1'b0, 7, 0, c0);
    send_req(1'b1, 1, 1, c1);
    chk(c1 == c0 + 4, "b2b_accept", $sformatf("write first cycle %0d, required %0d", c1, c0 + 4));
    wait_idle();
    send_req(1'b0, 0, DEPTH - 1, c0); wait_idle();

    for (int t = 0; t < 40; t++) begin
      wr   = int'($urandom % 2);
      addr = int'($urandom_range(0, 12));
      len  = ($urandom % 4 == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 5));
      set_beats(-1, 1'b1);
      send_req(wr[0], addr, len, c0);
      wait_idle();
    end
    send_req(1'b0, 0, DEPTH - 1, c0); wait_idle();

    repeat (3) @(posedge Clk);
    chk(sq.size() == 0 && rq.size() == 0 && evq.size() == 0, "queues_empty",
        $sformatf("pending %0d/%0d/%0d, required 0/0/0", sq.size(), rq.size(), evq.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the team's 8-bit single-port register-file memory (wr/rd/addr/Data_in/Data_out style; 1-cycle registered read; output undefined/Z when idle).
- Accepts burst read/write requests from a host over a valid/ready handshake.
- Sequences one memory strobe per cycle with address wrap-around, and returns read data and completion status.
- Sits between host logic and the memory instance; the memory is never driven directly by the host.

Parameters:
- DEPTH, 11, number of memory words; legal addresses 0..DEPTH-1
- AW, 4, address/length width
- DW, 8, data width

Ports:
- Clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  host request valid
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = write burst, 0 = read burst
- req_addr  input  AW  start address
- req_len  input  AW  burst beats minus one (beats = req_len+1)
- wdata_valid  input  1  host write data valid
- wdata_ready  output  1  controller accepts write data this cycle
- wdata  input  DW  write data
- rdata_valid  output  1  rdata holds a read beat this cycle
- rdata  output  DW  read data (pass-through of mem_rdata)
- done  output  1  one-cycle pulse when a burst completes
- err  output  1  one-cycle pulse when a request is rejected
- mem_wr  output  1  to memory wr
- mem_rd  output  1  to memory rd
- mem_addr  output  AW  to memory addr
- mem_wdata  output  DW  to memory Data_in
- mem_rdata  input  DW  from memory Data_out

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; registered outputs rdata_valid=0, done=0, err=0.
  - All combinational outputs evaluate to 0: req_ready=1 only after rst deasserts; mem_wr=0, mem_rd=0, wdata_ready=0, mem_addr=0.
- Reset mid-burst aborts immediately. No further strobes are issued, no done is produced, and already-written words remain in memory.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: if req_addr>=DEPTH or req_len>=DEPTH, pulse err next cycle and stay IDLE with no memory access.
  - Otherwise latch cur_addr=req_addr, remaining=req_len, and go to WRITE or READ.
- WRITE:
  - wdata_ready=1; mem_wr = wdata_valid (combinational); mem_addr=cur_addr; mem_wdata=wdata.
  - On each accepted beat, cur_addr advances.
  - If remaining==0, go to DONE; otherwise decrement remaining.
  - wdata_valid low stalls with no strobe; there is no timeout.
- READ:
  - mem_rd=1 every cycle; mem_addr=cur_addr; cur_addr advances each cycle.
  - If remaining==0, go to DRAIN; otherwise decrement remaining.
- Read data timing:
  - rdata_valid is mem_rd delayed one cycle, so it is also asserted during DRAIN.
  - rdata=mem_rdata. No backpressure on read data; the host must accept it.
- DRAIN: no strobes; last read beat is presented; go to DONE.
- DONE: done=1 for exactly one cycle; req_ready=0; go to IDLE.
- Address advance: next = (cur_addr==DEPTH-1) ? 0 : cur_addr+1. A wrapping burst is legal.
- Invariants:
  - mem_wr and mem_rd are never both 1.
  - When not strobing, mem_addr holds cur_addr; mem_rdata is ignored whenever rdata_valid=0, so Z/X from an idle memory is harmless.
- Latency, write burst with wdata_valid held high:
  - Acceptance edge at T0.
  - Strobes in cycles T0+1..T0+N.
  - done in cycle T0+N+1.
- Latency, read burst:
  - Strobes in cycles T0+1..T0+N.
  - rdata_valid in cycles T0+2..T0+N+1.
  - done in cycle T0+N+2.
- req_valid is ignored outside IDLE; the host must hold the request until req_ready.

Test Plan:
- Write then read: write addr=2, len=2, data 0xA1,0xB2,0xC3 → mem_wr strobes at addr 2,3,4 and done after 4 cycles. Then read addr=2, len=2 → rdata 0xA1,0xB2,0xC3 on consecutive rdata_valid cycles, then done.
- Wrap: write addr=9, len=3, data 0x11..0x44 → mem_addr sequence 9,10,0,1. Readback of addr 0 returns 0x33.
- Reject: req_addr=11 (or req_len=11) → err pulses once, no mem_wr/mem_rd, req_ready stays 1, no done.
- Write stall: write len=1 with wdata_valid low for 3 cycles between beats → exactly 2 mem_wr strobes; done only after the second beat.
- Reset mid-read: assert rst during the 2nd READ cycle of a len=4 burst → mem_rd drops immediately; rdata_valid=0 and done=0 after reset; next request accepted normally.
- Back-to-back: read len=0 immediately followed by a write request → exactly one rdata_valid; the write is accepted the cycle after done.
